// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_muldiv_unit                                                |
// | Purpose  : Iterative multiply/divide engine owning the MIPS HI/LO regs.    |
// |            Optional macro MIPS_MULDIV_FAST_MULT_EN: single-cycle multiply. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_1,
  input  logic [WIDTH-1:0] src_2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [ITER_CNT_W-1:0] c_ITERS = ITER_CNT_W'(WIDTH);
  localparam logic [ITER_CNT_W-1:0] c_ONE   = ITER_CNT_W'(1);

  logic [1:0]            r_state;
  logic                  r_is_div;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div_zero;
  logic [WIDTH-1:0]      r_operand;
  logic [2*WIDTH-1:0]    r_acc;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic                  r_done;
  logic                  r_div_by_zero;

  logic                  w_op_div;
  logic                  w_op_signed;
  logic                  w_neg_a;
  logic                  w_neg_b;
  logic [WIDTH-1:0]      w_mag_a;
  logic [WIDTH-1:0]      w_mag_b;
  logic [WIDTH-1:0]      w_addend;
  logic [WIDTH:0]        w_mul_sum;
  logic [2*WIDTH-1:0]    w_mul_next;
  logic [WIDTH:0]        w_div_diff;
  logic [2*WIDTH-1:0]    w_div_next;
  logic [2*WIDTH-1:0]    w_prod_fix;
  logic [WIDTH-1:0]      w_quot;
  logic [WIDTH-1:0]      w_rem;

  // op[1] selects divide, op[0] selects the unsigned variant
  assign w_op_div    = op[1];
  assign w_op_signed = ~op[0];
  assign w_neg_a     = w_op_signed & src_1[WIDTH-1];
  assign w_neg_b     = w_op_signed & src_2[WIDTH-1];
  assign w_mag_a     = w_neg_a ? (-src_1) : src_1;
  assign w_mag_b     = w_neg_b ? (-src_2) : src_2;

  // Shift-add multiply: multiplier sits in the low half and drains out the bottom
  assign w_addend   = r_acc[0] ? r_operand : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: trial-subtract from the partial remainder shifted left by one
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
  assign w_div_next = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
  assign w_quot     = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem      = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= c_IDLE;
      r_is_div      <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_div_zero    <= 1'b0;
      r_operand     <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (mthi) r_hi <= src_1;
          if (mtlo) r_lo <= src_1;
          if (start) begin
            r_is_div      <= w_op_div;
            r_neg_q       <= w_neg_a ^ w_neg_b;
            r_neg_r       <= w_neg_a;
            r_div_zero    <= w_op_div & (src_2 == '0);
            r_div_by_zero <= 1'b0;
            r_operand     <= w_op_div ? w_mag_b : w_mag_a;
            r_acc         <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
            r_cnt         <= c_ITERS;
            r_state       <= c_RUN;
`ifdef MIPS_MULDIV_FAST_MULT_EN
            if (!w_op_div) begin
              r_acc   <= w_fast_prod;
              r_cnt   <= '0;
              r_state <= c_FIX;
            end
`endif
          end
        end
        c_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - c_ONE;
          if (r_cnt == c_ONE) r_state <= c_FIX;
        end
        c_FIX: begin
          r_state <= c_IDLE;
          r_done  <= 1'b1;
          if (r_is_div) begin
            // A zero divisor still leaves the dividend as remainder; only lo is forced
            r_lo <= r_div_zero ? '1 : w_quot;
            r_hi <= w_rem;
            if (r_div_zero) r_div_by_zero <= 1'b1;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != c_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide engine that owns the architectural HI/LO registers of the MIPS datapath.
- Takes the same two operands the ALU receives (src_1 = rs, src_2 = rt) plus an op select from decode.
- Runs a 32-step shift-add multiply or shift-subtract divide, then exposes hi/lo to the ALU for MFHI/MFLO.
- Asserts busy so the pipeline can stall any HI/LO access until the operation completes.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- ITER_CNT_W, 6, width of the iteration counter; must be able to hold WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin an operation; sampled only in IDLE
- op  input  2  operation: 0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- src_1  input  WIDTH  multiplicand / dividend (rs)
- src_2  input  WIDTH  multiplier / divisor (rt)
- mthi  input  1  write src_1 into hi (MTHI)
- mtlo  input  1  write src_1 into lo (MTLO)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when a result lands in hi/lo
- div_by_zero  output  1  sticky flag; set by DIV/DIVU with src_2==0, cleared by next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, reset_n low): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States and transitions:
  - IDLE to RUN: on an edge with start=1. At that edge, latch op, latch operand magnitudes (absolute values for signed ops), record result signs, load counter=WIDTH, set busy=1.
  - RUN: one iteration per cycle. Multiply: add/shift into a 2*WIDTH accumulator. Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half. Counter decrements each cycle; move to FIX when the counter reaches 0 after WIDTH iterations.
  - FIX to IDLE: apply sign correction and write hi/lo; busy=0 and done=1 in the following cycle.
- Latency: start sampled at edge E0; busy=1 after E0 through edge E33. New hi/lo and done=1 are visible after E33; done returns to 0 after E34.
- Result rules:
  - Mult: {hi,lo} = full 2*WIDTH product. MULT negates the product if operand signs differ.
  - Div: lo = quotient, hi = remainder.
  - Signed div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- Divide by zero: no iteration is skipped; lo=0xFFFFFFFF, hi=src_1 as latched; div_by_zero=1.
- start while busy: ignored, with no queueing.
- mthi/mtlo: honoured only in IDLE, taking effect at that edge. Ignored while busy.
- mthi/mtlo and start in the same IDLE edge: the write applies, the operation starts, and the final result overwrites hi/lo.
- mthi and mtlo together: both hi and lo are loaded with src_1.
- Operand changes after the accepting edge have no effect on the result.

Optional Feature:
- Macro MIPS_MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle combinational multiplier and skip RUN. The FSM goes IDLE to FIX; result and done appear after E1, with busy high for one cycle. Divide is unchanged.
- Undefined: all ops are iterative with the 33-cycle latency above.

Test Plan:
- DIVU src_1=0x11111111, src_2=0x00000088, start 1 cycle -> after 33 busy cycles lo=0x00202020, hi=0x00000011, done pulses once.
- MULTU src_1=0x11111111, src_2=0x00000088 -> hi=0x00000009, lo=0x11111108. With MIPS_MULDIV_FAST_MULT_EN, the same values after 1 cycle.
- DIV src_1=-7 (0xFFFFFFF9), src_2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV by zero: src_1=0x1234, src_2=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. The next accepted start clears div_by_zero.
- Pulse start and mthi (src_1=0xAAAA) at cycle 5 of an op -> both ignored; final hi/lo equal the original op's result. After done, mtlo with src_1=6 -> lo=6.
- Drop reset_n at cycle 10 of DIVU -> busy=0, done=0, hi=lo=0 immediately. After release, a new MULTU 10x5 gives lo=50, hi=0.
